// File: rtl/pipe_pkg.sv
// Shared pipeline types: hazard controller states, register-specifier width and the
// per-register stall/flush control bundle consumed by the pipeline registers.
package pipe_pkg;

  localparam int unsigned REG_W = 3;

  typedef enum logic [1:0] {
    StRun,
    StRedirectWait,
    StDrain,
    StHalted
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_stall;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CtrlNone = '{
    pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b0, id_ex_stall: 1'b0,
    id_ex_flush: 1'b0, ex_mem_stall: 1'b0, mem_wb_stall: 1'b0
  };

  localparam pipe_ctrl_t CtrlAllStall = '{
    pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0, id_ex_stall: 1'b1,
    id_ex_flush: 1'b0, ex_mem_stall: 1'b1, mem_wb_stall: 1'b1
  };

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use comparator: the ID instruction reads the register a load in EX
// is about to write. R0 is compared like any other register.
module hazard_lu_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  output logic             lu
);

  assign lu = ex_memread && ((id_rs_used && (id_rs == ex_rd)) ||
                             (id_rt_used && (id_rt == ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, memory-busy freezes,
// redirects held across fetch waits, HALT drain. Perf counters exist only with HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned HALT_DRAIN = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_halt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_stall,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned DrainW = (HALT_DRAIN < 1) ? 1 : $clog2(HALT_DRAIN + 1);

  hz_state_e   state_q, state_d;
  logic [DrainW-1:0] cnt_q, cnt_d;
  pipe_ctrl_t  ctrl;
  logic        lu;

  hazard_lu_detect u_lu (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .lu         (lu)
  );

  always_comb begin
    ctrl    = CtrlNone;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!rst) begin
      case (state_q)
        StRun: begin
          if (dmem_busy) begin
            ctrl = CtrlAllStall;
          end else if (ex_branch_taken) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            if (imem_busy) state_d = StRedirectWait;
          end else if (lu) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (id_halt) begin
            // HALT moves on into EX; everything behind it is frozen from here on.
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            state_d          = StDrain;
            cnt_d            = DrainW'(HALT_DRAIN);
          end else if (imem_busy) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_flush = 1'b1;
          end
        end
        StRedirectWait: begin
          // The fetch in flight is wrong-path: hold PC on the target and discard it.
          if (dmem_busy) ctrl = CtrlAllStall;
          ctrl.pc_stall    = 1'b1;
          ctrl.if_id_flush = 1'b1;
          if (!imem_busy) state_d = StRun;
        end
        StDrain: begin
          if (dmem_busy) begin
            ctrl = CtrlAllStall;
          end else begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            cnt_d            = cnt_q - DrainW'(1);
            if (cnt_q <= DrainW'(1)) state_d = StHalted;
          end
        end
        StHalted: ctrl = CtrlAllStall;
        default:  state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_stall  = ctrl.id_ex_stall;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign mem_wb_stall = ctrl.mem_wb_stall;
  assign halted       = (state_q == StHalted);

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_ev, flush_ev;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign stall_ev = ctrl.pc_stall && (state_q != StHalted);
  assign flush_ev = !rst && (state_q == StRun) && !dmem_busy && ex_branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_ev && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (flush_ev && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: behavioural reference checked every cycle plus literal
// expectations at the scenario points.
module tb_hazard_ctrl;

  localparam int unsigned HALT_DRAIN = 3;
  localparam int unsigned CNT_W      = 16;
  localparam int M_RUN = 0, M_REDIR = 1, M_DRAIN = 2, M_HALT = 3;
  // ctrl vector order: {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem, mem_wb}
  localparam logic [6:0] ALL    = 7'b1101011;
  localparam logic [6:0] BUBBLE = 7'b1100100;
  localparam logic [6:0] BRANCH = 7'b0010100;
  localparam logic [6:0] IFETCH = 7'b1010000;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic id_rs_used, id_rt_used, id_halt, ex_memread, ex_branch_taken, imem_busy, dmem_busy;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_stall;
  logic halted;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [6:0] ctrl_v;

  int total, bad;
  bit chk_on;

  int m_mode = M_RUN, m_left = 0, m_stall = 0, m_flush = 0;
  int n_mode = M_RUN, n_left = 0, n_stall = 0, n_flush = 0;

  hazard_ctrl #(.HALT_DRAIN(HALT_DRAIN), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rs_used      (id_rs_used),
    .id_rt_used      (id_rt_used),
    .id_halt         (id_halt),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .imem_busy       (imem_busy),
    .dmem_busy       (dmem_busy),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_stall    (ex_mem_stall),
    .mem_wb_stall    (mem_wb_stall),
    .halted          (halted),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  assign ctrl_v = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                   ex_mem_stall, mem_wb_stall};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs = 3'd0; id_rt = 3'd0; ex_rd = 3'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; id_halt = 1'b0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decide what each register must do this cycle from the mode and the rules.
  always @(negedge clk) begin
    logic [6:0] e;
    logic lu_m;
    int lim;
    lim   = (1 << CNT_W) - 1;
    lu_m  = ex_memread && ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
    e     = 7'b0;
    n_mode = m_mode; n_left = m_left;
    n_flush = m_flush;
    if (rst) begin
      n_mode = M_RUN; n_left = 0;
    end else if (m_mode == M_HALT) begin
      e = ALL;
    end else if (m_mode == M_DRAIN) begin
      if (dmem_busy) e = ALL;
      else begin
        e = BUBBLE;
        n_left = m_left - 1;
        if (n_left <= 0) n_mode = M_HALT;
      end
    end else if (m_mode == M_REDIR) begin
      e = (dmem_busy ? ALL : 7'b0) | IFETCH;
      if (!imem_busy) n_mode = M_RUN;
    end else begin
      if (dmem_busy) e = ALL;
      else if (ex_branch_taken) begin
        e = BRANCH;
        if (m_flush < lim) n_flush = m_flush + 1;
        if (imem_busy) n_mode = M_REDIR;
      end else if (lu_m) e = BUBBLE;
      else if (id_halt) begin
        e = 7'b1100000; n_mode = M_DRAIN; n_left = HALT_DRAIN;
      end else if (imem_busy) e = IFETCH;
    end
    n_stall = (e[6] && m_mode != M_HALT && m_stall < lim) ? m_stall + 1 : m_stall;
    if (rst) begin n_stall = 0; n_flush = 0; end
    if (chk_on) begin
      chk("model_ctrl", ctrl_v, e);
      chk("model_halted", halted, m_mode == M_HALT);
`ifdef HAZARD_PERF_CNT_EN
      chk("model_stall_cnt", stall_cycles, m_stall);
      chk("model_flush_cnt", flush_events, m_flush);
`else
      chk("model_cnt_tied", {stall_cycles, flush_events}, 0);
`endif
    end
  end

  always @(posedge clk) begin
    m_mode  <= n_mode;
    m_left  <= n_left;
    m_stall <= n_stall;
    m_flush <= n_flush;
  end

  initial begin
    int seen;
    total = 0; bad = 0; chk_on = 1'b0; seen = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
    #3;
    chk("reset_ctrl", ctrl_v, 0);
    chk("reset_halted", halted, 0);
    chk("reset_cnt", {stall_cycles, flush_events}, 0);
    tick();

    // Load to R3, ID reads rs=R3: one bubble, then clear.
    ex_memread = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1'b1;
    #3 chk("lu_rs", ctrl_v, BUBBLE);
    tick();
    idle();
    #3 chk("lu_after", ctrl_v, 0);
    tick();
    ex_memread = 1'b1; ex_rd = 3'd0; id_rt = 3'd0; id_rt_used = 1'b1;
    #3 chk("lu_r0_rt", ctrl_v, BUBBLE);
    tick();
    idle(); ex_memread = 1'b1; ex_rd = 3'd5; id_rs = 3'd5; id_rt = 3'd5;
    #3 chk("lu_unused_src", ctrl_v, 0);
    tick();
    idle(); ex_rd = 3'd5; id_rs = 3'd5; id_rs_used = 1'b1;
    #3 chk("lu_not_load", ctrl_v, 0);
    tick();

    // Branch overrides the hazard.
    idle(); ex_memread = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1'b1;
    ex_branch_taken = 1'b1;
    #3 chk("lu_branch", ctrl_v, BRANCH);
    tick();

    // Taken branch with 3 busy fetch cycles then one ready cycle: flush on all four.
    idle(); ex_branch_taken = 1'b1; imem_busy = 1'b1;
    #3 chk("redirect_flush0", if_id_flush, 1);
    tick();
    ex_branch_taken = 1'b0;
    for (int k = 1; k < 4; k++) begin
      imem_busy = (k < 3);
      #3 chk("redirect_flush", if_id_flush, 1);
      tick();
    end
    idle();
    #3 chk("redirect_done", ctrl_v, 0);
    tick();

    // dmem_busy over a load-use: full freeze, then exactly one bubble.
    ex_memread = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1'b1; dmem_busy = 1'b1;
    repeat (2) begin
      #3 chk("dmem_lu_freeze", ctrl_v, ALL);
      tick();
    end
    dmem_busy = 1'b0;
    #3 chk("dmem_lu_bubble", ctrl_v, BUBBLE);
    tick();
    idle();
    #3 chk("dmem_lu_clear", ctrl_v, 0);
    tick();

    // Redirect wait with dmem_busy: stall everything and still flush IF/ID.
    ex_branch_taken = 1'b1; imem_busy = 1'b1;
    tick();
    ex_branch_taken = 1'b0; dmem_busy = 1'b1;
    #3 chk("redirect_dmem", ctrl_v, 7'b1111011);
    tick();
    imem_busy = 1'b0; dmem_busy = 1'b0;
    #3 chk("redirect_release", if_id_flush, 1);
    tick();
    idle();
    #3 chk("redirect_release_run", ctrl_v, 0);
    tick();

    // HALT on the wrong path of a taken branch is ignored.
    id_halt = 1'b1; ex_branch_taken = 1'b1;
    #3 chk("halt_branch", ctrl_v, BRANCH);
    tick();
    idle();
    #3 chk("halt_branch_run", ctrl_v, 0);
    tick();

    // Counters: 4 stall cycles and 2 accepted branches after a reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_busy = 1'b1;
    repeat (4) tick();
    imem_busy = 1'b0; ex_branch_taken = 1'b1;
    repeat (2) tick();
    idle();
`ifdef HAZARD_PERF_CNT_EN
    #3 chk("perf_stall", stall_cycles, 4);
    chk("perf_flush", flush_events, 2);
`else
    #3 chk("perf_tied", {stall_cycles, flush_events}, 0);
`endif
    tick();
    rst = 1'b1; imem_busy = 1'b1;
    #3 chk("rst_gates_ctrl", ctrl_v, 0);
    tick();
    rst = 1'b0; idle();
    #3 chk("perf_cleared", {stall_cycles, flush_events}, 0);
    tick();

    // HALT drain with two dmem_busy cycles: halted appears 5 edges after entering DRAIN.
    id_halt = 1'b1;
    #3 chk("halt_accept", {halted, ctrl_v}, 8'b01100000);
    tick();
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      dmem_busy = (k == 2 || k == 3);
      #3 if (halted) seen = k;
      tick();
    end
    chk("halt_latency", seen - 1, 5);
    ex_branch_taken = 1'b1; imem_busy = 1'b1; ex_memread = 1'b1; ex_rd = 3'd1;
    id_rs = 3'd1; id_rs_used = 1'b1; dmem_busy = 1'b0;
    repeat (3) begin
      #3 chk("halted_hold", {halted, ctrl_v}, {1'b1, ALL});
      tick();
    end
    rst = 1'b1;
    #3 chk("halted_rst_ctrl", ctrl_v, 0);
    tick();
    rst = 1'b0; idle();
    #3 chk("halted_cleared", halted, 0);
    tick();
    repeat (2) tick();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
